// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format follows the opcode alone, independent of state.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_dec.sv
// Combinational ALU decoder: fixed add/sub or funct3-driven operation.
module riscv_alu_dec
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  // Select the ALU operation from aluop, falling back to funct3 decode.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM with memory handshake, illegal trap and retire counter.
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] Instr,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Illegal,
  output logic [CNT_W-1:0] Retired
);

  state_t     state, state_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [1:0] aluop;
  logic       retire;
  logic       unused_instr_bits;

  assign op       = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign funct7b5 = Instr[30];
  assign unused_instr_bits = ^{Instr[width-1:31], Instr[29:15], Instr[11:7]};

  riscv_alu_dec u_alu_dec (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl)
  );

  // State register, sticky trap flag and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_FETCH;
      Illegal <= 1'b0;
      Retired <= '0;
    end else begin
      state <= state_n;
      if (state_n == S_TRAP) Illegal <= 1'b1;
      if (retire) Retired <= Retired + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode; reset forces all enables low.
  always_comb begin
    state_n   = state;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = imm_src(op);
    aluop     = ALUOP_ADD;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_n = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_RTYPE:          state_n = S_EXECR;
          OP_ITYPE:          state_n = S_EXECI;
          OP_BRANCH:         state_n = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_n = S_JAL;
          default:           state_n = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        aluop   = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        aluop   = ALUOP_SUB;
        PCWrite = Zero ^ funct3[0];
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_n = S_ALUWB;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
    if (RST) begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench: directed scenarios then randomized instruction stream
// checked against a per-instruction step-plan model.
module tb_riscv_multicycle_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [31:0]   Instr = 32'h0000_2083;
  logic          Zero = 1'b0;
  logic          MemReady = 1'b1;
  logic          MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]    ALUControl;
  logic [CW-1:0] Retired;

  riscv_multicycle_ctrl #(.width(32), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Illegal(Illegal), .Retired(Retired)
  );

  always #5 CLK = ~CLK;

  // Instruction steps as seen by the bench model.
  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MW = 5;
  localparam int PH_XR = 6, PH_XI = 7, PH_AWB = 8, PH_BR = 9, PH_J = 10, PH_T = 11;

  int   phase = PH_F;
  int   plan[$];
  int   ret_m = 0;
  bit   known = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   mw_cnt = 0;
  int   trap_cycles = 0;
  logic last_pcw;
  logic [2:0] last_alu;

  function automatic logic [2:0] exp_funct_alu(input logic [31:0] i);
    case (i[14:12])
      3'b000:  return (i[5] && i[30]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [31:0] i);
    case (i[6:0])
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // Expected control word for a step: {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,
  // RegWrite,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl,Illegal}.
  function automatic logic [17:0] exp_ctl(input int ph, input logic [31:0] i,
                                          input logic rdy, input logic z, input logic rst);
    logic mreq, mw, adr, irw, pcw, rw, ill;
    logic [1:0] sa, sb, rs;
    logic [2:0] alu;
    {mreq, mw, adr, irw, pcw, rw, ill} = '0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00; alu = 3'b000;
    case (ph)
      PH_F:   begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      PH_D:   begin sa = 2'b01; sb = 2'b01; end
      PH_MA:  begin sa = 2'b10; sb = 2'b01; end
      PH_MR:  begin mreq = 1; adr = 1; end
      PH_MWB: begin rs = 2'b01; rw = 1; end
      PH_MW:  begin mreq = 1; mw = 1; adr = 1; end
      PH_XR:  begin sa = 2'b10; alu = exp_funct_alu(i); end
      PH_XI:  begin sa = 2'b10; sb = 2'b01; alu = exp_funct_alu(i); end
      PH_AWB: rw = 1;
      PH_BR:  begin sa = 2'b10; alu = 3'b001; pcw = z ^ i[12]; end
      PH_J:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      PH_T:   ill = 1;
      default: ;
    endcase
    if (rst) {mreq, mw, irw, pcw, rw} = '0;
    return {mreq, mw, adr, irw, pcw, rw, sa, sb, rs, exp_imm(i), alu, ill};
  endfunction

  task automatic build_plan(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    case (op)
      7'b0000011: plan = '{PH_D, PH_MA, PH_MR, PH_MWB};
      7'b0100011: plan = '{PH_D, PH_MA, PH_MW};
      7'b0110011: plan = '{PH_D, PH_XR, PH_AWB};
      7'b0010011: plan = '{PH_D, PH_XI, PH_AWB};
      7'b1100011: plan = (f3 == 3'b000 || f3 == 3'b001) ? '{PH_D, PH_BR} : '{PH_D, PH_T};
      7'b1101111: plan = '{PH_D, PH_J, PH_AWB};
      default:    plan = '{PH_D, PH_T};
    endcase
  endtask

  // Advance the model across one clock edge; an instruction retires when its
  // plan runs out (trap plans never run out).
  task automatic advance(input logic rst, input logic rdy);
    if (rst) begin
      phase = PH_F; plan.delete(); ret_m = 0; known = 1'b1;
    end else if (phase == PH_T) begin
    end else if (phase == PH_F) begin
      if (rdy) begin build_plan(Instr); phase = plan.pop_front(); end
    end else if ((phase == PH_MR || phase == PH_MW) && !rdy) begin
    end else if (plan.size() == 0) begin
      ret_m = (ret_m + 1) % (1 << CW);
      phase = PH_F;
    end else begin
      phase = plan.pop_front();
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h phase=%0d instr=%h", tag, obs, exp, phase, Instr);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic z);
    @(negedge CLK);
    RST = rst; MemReady = rdy; Zero = z;
    #1;
    if (known) begin
      check_eq("ctl",
               32'({MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                    ResultSrc, ImmSrc, ALUControl, Illegal}),
               32'(exp_ctl(phase, Instr, rdy, z, rst)));
      check_eq("retired", 32'(Retired), 32'(ret_m));
    end else begin
      check_eq("rst_enables", 32'({MemReq, MemWrite, IRWrite, PCWrite, RegWrite}), 32'(0));
    end
    if (MemWrite) mw_cnt++;
    last_pcw = PCWrite;
    last_alu = ALUControl;
    @(posedge CLK);
    advance(rst, rdy);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] op;
    logic [2:0] f3;
    r  = $urandom;
    f3 = r[14:12];
    case ($urandom_range(0, 11))
      0, 1:    begin op = 7'b0000011; f3 = 3'b010; end
      2, 3:    begin op = 7'b0100011; f3 = 3'b010; end
      4, 5:    op = 7'b0110011;
      6, 7:    op = 7'b0010011;
      8, 9:    begin op = 7'b1100011; f3 = {2'b00, r[12]}; end
      10:      op = ($urandom_range(0, 1) == 0) ? 7'b1101111 : 7'b1100011;
      default: op = r[6:0];
    endcase
    r[6:0] = op;
    r[14:12] = f3;
    return r;
  endfunction

  int prev;

  initial begin
    // Reset held two cycles with MemReady high.
    step(1, 1, 0);
    step(1, 1, 0);
    // lw x1,0(x0), zero wait.
    Instr = 32'h0000_2083;
    step(0, 1, 0);
    check_eq("fetch_pcwrite", 32'(last_pcw), 32'(1));
    repeat (4) step(0, 1, 0);
    #1 check_eq("lw_retired", 32'(Retired), 32'(1));

    // sw with three wait states in MEMWRITE.
    Instr = 32'h0010_2023;
    mw_cnt = 0;
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 1, 0);
    #1;
    check_eq("sw_memwrite_cycles", 32'(mw_cnt), 32'(4));
    check_eq("sw_retired", 32'(Retired), 32'(2));

    // sw abandoned by reset in its second MEMWRITE cycle.
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    #1;
    check_eq("sw_rst_memwrite", 32'(MemWrite), 32'(0));
    check_eq("sw_rst_retired", 32'(Retired), 32'(0));

    // bne / beq with both Zero values.
    Instr = 32'h0010_1463;
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    check_eq("bne_alu", 32'(last_alu), 32'(3'b001));
    check_eq("bne_z0_pcw", 32'(last_pcw), 32'(1));
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 1);
    check_eq("bne_z1_pcw", 32'(last_pcw), 32'(0));
    Instr = 32'h0010_0463;
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    check_eq("beq_z0_pcw", 32'(last_pcw), 32'(0));
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 1);
    check_eq("beq_z1_pcw", 32'(last_pcw), 32'(1));

    // sub in EXECR, addi with imm bit 30 set in EXECI.
    Instr = 32'h4020_8033;
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    check_eq("sub_alu", 32'(last_alu), 32'(3'b001));
    step(0, 1, 0);
    Instr = 32'hC000_0093;
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    check_eq("addi_alu", 32'(last_alu), 32'(3'b000));
    step(0, 1, 0);

    // Illegal opcode traps until reset.
    Instr = 32'h0000_007F;
    step(0, 1, 0); step(0, 1, 0);
    repeat (10) step(0, 1, 0);
    check_eq("trap_illegal", 32'(Illegal), 32'(1));
    step(1, 1, 0);
    #1 check_eq("trap_cleared", 32'(Illegal), 32'(0));

    // 16 addi: the 4-bit counter wraps back to its start.
    Instr = 32'h0010_0093;
    prev = 32'(Retired);
    repeat (16) begin step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); end
    #1 check_eq("wrap", 32'(Retired), 32'(prev));

    // Randomized stream with random wait states, Zero and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      logic r_rst;
      if (phase == PH_F) Instr = rand_instr();
      r_rst = ($urandom_range(0, 79) == 0);
      if (phase == PH_T) begin
        trap_cycles++;
        if (trap_cycles > $urandom_range(2, 12)) r_rst = 1'b1;
      end
      if (r_rst) trap_cycles = 0;
      step(r_rst, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Parametrised multi-cycle control unit for the next-generation RISC-V core. A unified instruction/data memory with a variable-latency ready handshake replaces the separate single-cycle memories. The block sequences each instruction through a Moore FSM and drives every datapath enable and mux select. It adds bne, a sticky illegal-instruction trap and a retired-instruction counter.

## Interface
- `width`, 32, instruction width in bits; must be ≥ 32.
- `CNT_W`, 32, width of the retired-instruction counter.

- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Instr`  in  width  contents of the instruction register; only bits [6:0], [14:12] and [30] are used.
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  memory completion; sampled only while `MemReq`=1.
- `MemReq`  out  1  memory access request.
- `MemWrite`  out  1  store strobe.
- `AdrSrc`  out  1  memory address select: 0 selects PC, 1 selects Result.
- `IRWrite`, `PCWrite`, `RegWrite`  out  1 each  register enables.
- `ALUSrcA`  out  2  SrcA select: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB`  out  2  SrcB select: 00 RD2, 01 ImmExt, 10 constant 4.
- `ResultSrc`  out  2  Result select: 00 ALUOut, 01 Data, 10 ALUResult.
- `ImmSrc`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- `ALUControl`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `Illegal`  out  1  sticky trap flag.
- `Retired`  out  CNT_W  count of completed instructions.

## Operation
**States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.

Unless listed below, every output is 0.

**FETCH**
- Outputs: MemReq=1, ALUSrcB=10, ResultSrc=10.
- IRWrite = PCWrite = MemReady.
- Leaves for DECODE on MemReady; otherwise holds.

**DECODE**
- Outputs: ALUSrcA=01, ALUSrcB=01, add. This computes the branch target.
- Transition by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH if funct3 is 000 or 001; otherwise TRAP.
  - 1101111 → JAL.
  - Any other opcode → TRAP.

**MEMADR**
- Outputs: ALUSrcA=10, ALUSrcB=01, add.
- Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.

**MEMREAD**
- Outputs: MemReq=1, AdrSrc=1.
- Goes to MEMWB on MemReady.

**MEMWB**
- Outputs: ResultSrc=01, RegWrite=1.
- Goes to FETCH.

**MEMWRITE**
- Outputs: MemReq=1, MemWrite=1, AdrSrc=1.
- Goes to FETCH on MemReady.

**EXECR / EXECI**
- Outputs: ALUSrcA=10; ALUSrcB=00 in EXECR, 01 in EXECI.
- ALU decode by funct3:
  - 000: sub only if op[5] and Instr[30] are both 1; otherwise add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.
- Goes to ALUWB.

**ALUWB**
- Outputs: RegWrite=1.
- Goes to FETCH.

**BRANCH**
- Outputs: ALUSrcA=10, sub.
- PCWrite = Zero XOR funct3[0]. This gives beq with funct3 000 and bne with funct3 001.
- Goes to FETCH.

**JAL**
- Outputs: ALUSrcA=01, ALUSrcB=10, add, PCWrite=1.
- Goes to ALUWB.

**TRAP**
- All enables 0; Illegal=1.
- Holds until RST.

**ImmSrc** is decoded combinationally from the opcode in every state:
- 0100011 → S.
- 1100011 → B.
- 1101111 → J.
- Any other opcode → I.

**Retired**
- Increments by 1 in these cycles: MEMWB, ALUWB, BRANCH, and the final MEMWRITE cycle (MemReady=1).
- Wraps modulo 2^CNT_W.

## Timing
- **Reset:** on a clock edge with RST=1, state ← FETCH, Illegal ← 0 and Retired ← 0.
- **Enables during reset:** while RST=1, MemReq, MemWrite, IRWrite, PCWrite and RegWrite are forced to 0 combinationally.
- **Reset mid-operation:** RST has priority over MemReady. A pending access is abandoned and its enables drop in the same cycle.
- **Handshake:**
  - MemReq stays high, and AdrSrc and MemWrite stay stable, until the first edge at which MemReady=1.
  - If MemReady is already high, the access takes one cycle.
  - Each wait cycle adds one cycle and produces no side effects.
- **Zero-wait latency:** lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4 cycles.
- **Outputs:** Moore, decoded from registered state. PCWrite in BRANCH additionally depends on Zero and funct3; IRWrite and PCWrite in FETCH also depend on MemReady.

## Structure
- **Package `riscv_pkg`** holds:
  - the state encoding;
  - opcode constants;
  - ALUControl, ImmSrc, ALUSrcA, ALUSrcB and ResultSrc codes.
- **Sub-module `riscv_alu_dec`:** combinational ALU decoder. Inputs: ALUOp[1:0] (00 add, 01 sub, 10 funct), funct3, op[5], Instr[30]. Output: ALUControl.
- **Top of `riscv_multicycle_ctrl`** contains the FSM, the Illegal flag and the Retired counter.

## Test plan
1. **Reset:** RST=1 for 2 cycles with MemReady=1 → MemReq, PCWrite and IRWrite are 0 while RST is high; first cycle after release is FETCH with MemReq=1 and PCWrite=1; Retired=0.
2. **lw, zero wait:** Instr=0x00002083 (lw x1,0(x0)), MemReady=1 → sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; Retired 0→1.
3. **sw with wait states:** Instr=0x00102023 (sw x1,0(x0)), MemReady low for 3 cycles in MEMWRITE → MemWrite and MemReq high for exactly 4 cycles; Retired increments once. Repeat with RST asserted in the 2nd MEMWRITE cycle → next cycle is FETCH, MemWrite=0, no increment.
4. **bne:** Instr=0x00101463 → BRANCH has ALUControl=001. Zero=0 gives PCWrite=1; Zero=1 gives PCWrite=0. With funct3=000 (0x00100463) the PCWrite polarity is inverted.
5. **ALU decode:** Instr=0x40208033 (sub) → EXECR with ALUControl=001. Instr=0xC0000093 (addi, imm bit 30 set) → EXECI with ALUControl=000.
6. **Trap and wrap:** Instr=0x0000007F → TRAP, Illegal=1, all enables 0 for 10 cycles; RST clears Illegal. With CNT_W=4, 16 addi instructions → Retired wraps 15→0.
